// File: rtl/serial_tx.sv
// Framed parallel-to-serial transmitter: start bit, DATA_W data bits LSB first, stop bit,
// each bit held for CLKS_PER_BIT cycles. Line idles high.
module serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitMax = BitW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;
  logic [DATA_W-1:0] shift_next;

  assign din_ready  = (state_q == StIdle) && !rst;
  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bit_end    = (cnt_q == CntMax);
  assign shift_next = shift_q >> 1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = bit_end ? '0 : cnt_q + CntW'(1);

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (din_valid) begin
          shift_d = din;
          state_d = StStart;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q != BitMax) begin
            shift_d = shift_next;
            tx_d    = shift_next[0];
            bit_d   = bit_q + BitW'(1);
          end else begin
            state_d = StStop;
            tx_d    = 1'b1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       valid0, valid1;
  logic       ready0, tx0, busy0, done0;
  logic       ready1, tx1, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done0) done_cnt0 <= done_cnt0 + 1;
    if (done1) done_cnt1 <= done_cnt1 + 1;
  end

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(valid0),
    .din_ready(ready0),
    .tx_out   (tx0),
    .busy     (busy0),
    .done     (done0)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(valid1),
    .din_ready(ready1),
    .tx_out   (tx1),
    .busy     (busy1),
    .done     (done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) valid1 = v;
    else valid0 = v;
  endtask

  // Called just after a clock edge with the selected unit idle. Returns the accept cycle.
  task automatic run_frame(input bit sel, input logic [7:0] word, input int cpb,
                           input bit hold_valid, input bit interfere, output int acc_cyc);
    logic [9:0] frame;
    frame = {1'b1, word, 1'b0};
    check("ready_before", sel ? ready1 : ready0, 1);
    din = word;
    set_valid(sel, 1'b1);
    tick();
    acc_cyc = cyc;
    if (!hold_valid) set_valid(sel, 1'b0);
    for (int k = 0; k < 10 * cpb; k++) begin
      check($sformatf("tx_c%0d", k), sel ? tx1 : tx0, frame[k / cpb]);
      check("busy_in_frame", sel ? busy1 : busy0, 1);
      check("done_in_frame", sel ? done1 : done0, 0);
      check("ready_in_frame", sel ? ready1 : ready0, 0);
      if (interfere) begin
        din = 8'hFF;
        set_valid(sel, (k % 7 == 3) && (k < 10 * cpb - 2));
      end
      tick();
    end
    check("done_pulse", sel ? done1 : done0, 1);
    check("busy_idle", sel ? busy1 : busy0, 0);
    check("tx_idle", sel ? tx1 : tx0, 1);
    check("ready_idle", sel ? ready1 : ready0, 1);
    if (!hold_valid) begin
      tick();
      check("done_one_cycle", sel ? done1 : done0, 0);
      check("tx_after", sel ? tx1 : tx0, 1);
      check("busy_after", sel ? busy1 : busy0, 0);
    end
  endtask

  initial begin
    int a0, a1, dc;
    rst    = 1'b1;
    din    = 8'h00;
    valid0 = 1'b1;
    valid1 = 1'b1;

    // Reset held three cycles with valid asserted: nothing may start.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_tx", tx0, 1);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_ready", ready0, 0);
      check("rst_busy1", busy1, 0);
      check("rst_ready1", ready1, 0);
    end
    rst    = 1'b0;
    valid0 = 1'b0;
    valid1 = 1'b0;
    #1;
    check("ready_after_rst", ready0, 1);
    tick();
    check("idle_tx", tx0, 1);
    check("idle_busy", busy0, 0);

    // Single frame 0xA5.
    run_frame(0, 8'hA5, 4, 0, 0, a0);
    check("done_count_a5", done_cnt0, 1);

    // Back-to-back 0x3C then 0xC3 with valid held.
    dc = done_cnt0;
    run_frame(0, 8'h3C, 4, 1, 0, a0);
    run_frame(0, 8'hC3, 4, 0, 0, a1);
    check("b2b_gap", a1 - a0, 41);
    check("b2b_done_count", done_cnt0 - dc, 2);

    // Busy interference: 0xFF offered during the 0xA5 frame.
    dc = done_cnt0;
    run_frame(0, 8'hA5, 4, 0, 1, a0);
    for (int i = 0; i < 6; i++) tick();
    check("no_extra_busy", busy0, 0);
    check("no_extra_tx", tx0, 1);
    check("interf_done_count", done_cnt0 - dc, 1);

    // Reset during data bit 3 (cycles 16..19 of the frame).
    dc = done_cnt0;
    din    = 8'h96;
    valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("pre_rst_busy", busy0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_tx", tx0, 1);
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_ready", ready0, 1);
    for (int i = 0; i < 30; i++) tick();
    check("abort_no_done", done_cnt0 - dc, 0);
    run_frame(0, 8'h5A, 4, 0, 0, a0);

    // One clock per bit.
    run_frame(1, 8'h00, 1, 0, 0, a0);
    run_frame(1, 8'hFF, 1, 0, 0, a0);
    check("cpb1_done_count", done_cnt1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
